// File: rtl/fft_pkg.sv
// Shared types and default geometry for the FFT sequencer slice.
package fft_pkg;

  typedef enum logic [1:0] {LOAD, CALC, DRAIN, UNLOAD} seq_state_t;

  localparam int DEF_NUM_SAMPLES = 8;
  localparam int DEF_NUM_STAGES  = 3;
  localparam int DEF_BFLY_LAT    = 2;

endpackage

// File: rtl/fft_sequencer_if.sv
// Sequencer-facing bundle: upstream/downstream handshakes plus the counts and
// enables consumed by the sample buffer and the butterfly datapath.
interface fft_sequencer_if #(
  parameter int CW = 4,
  parameter int SW = 2
) ();
  // Handshake: a transfer happens in a cycle where valid and ready are both
  // high; the matching shift_*_ena is exactly that AND (forced low on abort).
  logic          in_valid;
  logic          in_ready;
  logic          shift_in_ena;
  logic [CW-1:0] samples_in_count;
  logic          iteration_ena;
  logic [SW-1:0] stage_count;
  logic [CW-1:0] iteration_count;
  logic          out_valid;
  logic          out_ready;
  logic          shift_out_ena;
  logic [CW-1:0] samples_out_count;
  logic          fft_done;
  logic          busy;

  modport master (
    input  in_valid, out_ready,
    output in_ready, shift_in_ena, samples_in_count, iteration_ena,
           stage_count, iteration_count, out_valid, shift_out_ena,
           samples_out_count, fft_done, busy
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, shift_in_ena, samples_in_count, iteration_ena,
           stage_count, iteration_count, out_valid, shift_out_ena,
           samples_out_count, fft_done, busy
  );
endinterface

// File: rtl/fft_sequencer_flex_counter.sv
// Up-counter with synchronous clear that wraps to 0 after reaching rollover_val.
module flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count_out
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      if (count_out == rollover_val) count_out <= '0;
      else                           count_out <= count_out + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fft_sequencer.sv
// Phase controller for the FFT core: load samples, run butterfly stages with a
// pipeline drain between them, then unload results.
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int BFLY_LAT    = DEF_BFLY_LAT,
  parameter int CW          = $clog2(NUM_SAMPLES) + 1,
  parameter int SW          = $clog2(NUM_STAGES + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            abort,
  fft_sequencer_if.master bus,
  output seq_state_t      dbg_state
);

  localparam int DW = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;

  localparam logic [CW-1:0] FULL_COUNT  = CW'(NUM_SAMPLES);
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(NUM_SAMPLES - 1);
  localparam logic [CW-1:0] LAST_ITER   = CW'(NUM_SAMPLES / 2 - 1);
  localparam logic [DW-1:0] LAST_DRAIN  = DW'(BFLY_LAT - 1);
  localparam logic [SW-1:0] LAST_STAGE  = SW'(NUM_STAGES - 1);

  seq_state_t    state;
  logic [SW-1:0] stage_q;
  logic          done_q;

  logic [CW-1:0] in_cnt;
  logic [CW-1:0] iter_cnt;
  logic [CW-1:0] out_cnt;
  logic [DW-1:0] drain_cnt;

  logic in_ready_w, out_valid_w, iter_ena_w, drain_ena_w;
  logic in_hs, out_hs, last_in, last_out, calc_last, drain_last, frame_clr;

  assign in_ready_w  = (state == LOAD);
  assign out_valid_w = (state == UNLOAD);
  assign iter_ena_w  = (state == CALC);
  assign drain_ena_w = (state == DRAIN);

  // An abort cycle never counts as a transfer on either side.
  assign in_hs  = bus.in_valid  & in_ready_w  & ~abort;
  assign out_hs = bus.out_ready & out_valid_w & ~abort;

  assign last_in    = in_hs  && (in_cnt  == LAST_SAMPLE);
  assign last_out   = out_hs && (out_cnt == LAST_SAMPLE);
  assign calc_last  = iter_ena_w  && (iter_cnt  == LAST_ITER);
  assign drain_last = drain_ena_w && (drain_cnt == LAST_DRAIN);
  assign frame_clr  = abort | last_out;

  flex_counter #(.WIDTH(CW)) u_in_cnt (
    .clk(clk), .rst(rst), .clear(frame_clr), .count_enable(in_hs),
    .rollover_val(FULL_COUNT), .count_out(in_cnt)
  );

  flex_counter #(.WIDTH(CW)) u_iter_cnt (
    .clk(clk), .rst(rst), .clear(abort), .count_enable(iter_ena_w),
    .rollover_val(LAST_ITER), .count_out(iter_cnt)
  );

  flex_counter #(.WIDTH(DW)) u_drain_cnt (
    .clk(clk), .rst(rst), .clear(abort), .count_enable(drain_ena_w),
    .rollover_val(LAST_DRAIN), .count_out(drain_cnt)
  );

  flex_counter #(.WIDTH(CW)) u_out_cnt (
    .clk(clk), .rst(rst), .clear(frame_clr), .count_enable(out_hs),
    .rollover_val(FULL_COUNT), .count_out(out_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      stage_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last_out;
      if (abort) begin
        state   <= LOAD;
        stage_q <= '0;
      end else begin
        case (state)
          LOAD:   if (last_in) state <= CALC;
          CALC:   if (calc_last) state <= DRAIN;
          DRAIN: begin
            if (drain_last) begin
              if (stage_q < LAST_STAGE) begin
                stage_q <= stage_q + SW'(1);
                state   <= CALC;
              end else begin
                state <= UNLOAD;
              end
            end
          end
          UNLOAD: begin
            if (last_out) begin
              state   <= LOAD;
              stage_q <= '0;
            end
          end
          default: state <= LOAD;
        endcase
      end
    end
  end

  assign bus.in_ready          = in_ready_w;
  assign bus.shift_in_ena      = in_hs;
  assign bus.samples_in_count  = in_cnt;
  assign bus.iteration_ena     = iter_ena_w;
  assign bus.stage_count       = stage_q;
  assign bus.iteration_count   = iter_cnt;
  assign bus.out_valid         = out_valid_w;
  assign bus.shift_out_ena     = out_hs;
  assign bus.samples_out_count = out_cnt;
  assign bus.fft_done          = done_q;
  assign bus.busy              = (state != LOAD);
  assign dbg_state             = state;

endmodule

// File: doc/fft_sequencer.md
# fft_sequencer

Control FSM for the FFT core. It sequences the sample-load, butterfly-compute and sample-unload phases. It drives the shift/iteration enables and the sample, stage and iteration counts consumed by the sample buffer and the butterfly datapath. It sits between the upstream sample source (valid/ready), the butterfly unit and the downstream sink (valid/ready). It owns all phase counting, so no separate timer block is needed alongside it.

## Interface
Parameters:
- NUM_SAMPLES, 8: FFT points; power of two, ≥4.
- NUM_STAGES, 3: log2(NUM_SAMPLES).
- BFLY_LAT, 2: butterfly pipeline depth in cycles; drain time between stages, ≥1.
- CW, $clog2(NUM_SAMPLES)+1: count width (4 at defaults).
- SW, $clog2(NUM_STAGES+1): stage width (2 at defaults).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- abort  in  1  cancel the current transform; return to LOAD.
- in_valid  in  1  upstream sample available.
- in_ready  out  1  sequencer can accept a sample.
- shift_in_ena  out  1  in_valid & in_ready; buffer shifts a sample in.
- samples_in_count  out  CW  samples accepted in this frame.
- iteration_ena  out  1  issue one butterfly this cycle.
- stage_count  out  SW  current stage, 0..NUM_STAGES-1.
- iteration_count  out  CW  butterfly index within the stage, 0..NUM_SAMPLES/2-1.
- out_valid  out  1  result sample available.
- out_ready  in  1  downstream accepts.
- shift_out_ena  out  1  out_valid & out_ready.
- samples_out_count  out  CW  samples delivered in this frame.
- fft_done  out  1  one-cycle pulse after the frame's last output handshake.
- busy  out  1  high in CALC, DRAIN and UNLOAD.

## Operation
- States: LOAD, CALC, DRAIN, UNLOAD. Reset state is LOAD.
- LOAD: in_ready=1. Each handshake increments samples_in_count. The handshake that brings the count to NUM_SAMPLES moves the FSM to CALC. The count holds at NUM_SAMPLES until LOAD is re-entered.
- CALC: iteration_ena=1 every cycle. iteration_count increments each cycle. When iteration_count=NUM_SAMPLES/2-1, the next state is DRAIN and iteration_count wraps to 0.
- DRAIN: iteration_ena=0. An internal counter runs for BFLY_LAT cycles. On its last cycle:
  - if stage_count<NUM_STAGES-1: stage_count increments and the next state is CALC;
  - otherwise the next state is UNLOAD and stage_count holds.
- UNLOAD: out_valid=1. Each handshake increments samples_out_count. When the NUM_SAMPLES-th handshake occurs:
  - next state is LOAD;
  - all counts clear to 0;
  - fft_done is registered high for the next cycle only.
- in_valid is ignored outside LOAD; out_ready is ignored outside UNLOAD.
- abort has priority over every transition. Next cycle: state is LOAD and all counts are 0. No fft_done is produced. The abort cycle is treated as a non-handshake: in that cycle shift_in_ena and shift_out_ena are forced to 0.
- rst has priority over abort.
- Counts never exceed NUM_SAMPLES; there is no wrap beyond a frame.

## Timing
- Reset values: state LOAD, in_ready=1, every other output 0, all counts 0.
- in_ready, out_valid, iteration_ena, busy and the enables are decoded combinationally from the registered state (Moore), except shift_*_ena, which is a handshake AND.
- Counts and fft_done are registered.
- First CALC cycle follows the last input handshake by exactly 1 cycle.
- Compute phase lasts NUM_STAGES*(NUM_SAMPLES/2+BFLY_LAT) cycles: 18 at defaults.
- First out_valid follows the last butterfly issue by BFLY_LAT cycles, plus 1 cycle of state register.
- Back-to-back frames: in_ready is high in the cycle after the last output handshake. That is the same cycle in which fft_done is high.
- Handshakes at full rate give one sample per cycle in both directions.

## Structure
- fft_pkg holds:
  - typedef enum logic [1:0] seq_state_t {LOAD, CALC, DRAIN, UNLOAD};
  - the default NUM_SAMPLES, NUM_STAGES and BFLY_LAT constants.
- Sub-module flex_counter (parameterized width, rollover value, clear and count_enable, synchronous active-high reset). It is instantiated for the sample-in, iteration, drain and sample-out counts.
- Stage count is a small register in the top-level module.

## Test plan
- Reset, then 8 consecutive input handshakes. Expected: samples_in_count steps 1..8, in_ready drops the cycle after the 8th, and iteration_ena rises that cycle.
- Free-running compute. Expected: iteration_ena pattern is 4 high, 2 low, repeated three times, with stage_count 0,1,2. out_valid rises 18 cycles after CALC entry.
- Unload with out_ready toggling 1,0,1,0. Expected: samples_out_count advances only on handshake cycles, and fft_done pulses once, 1 cycle after the 8th handshake.
- in_valid held low for 3 cycles mid-load (after sample 5). Expected: count holds at 5 and the FSM stays in LOAD.
- abort during CALC stage 1. Expected: next cycle state is LOAD, all counts are 0, and no fft_done pulse occurs. A following full frame completes normally.
- rst asserted during UNLOAD with out_ready=1. Expected: next cycle all outputs are at reset values and shift_out_ena is 0.
